// File: rtl/tinker_pkg.sv
// Shared widths, reset address and the prefetch-queue entry type for the tinker core.
package tinker_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] TINKER_RESET_PC = 64'h2000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc4;
  } fetch_entry_t;

endpackage

// File: rtl/tinker_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface tinker_fetch_unit_if;
  import tinker_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_rsp_valid;
  logic [INSTR_W-1:0]  imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/tinker_fetch_fifo.sv
// Registered prefetch queue of fetch entries with synchronous flush and occupancy count.
module tinker_fetch_fifo
  import tinker_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    data_i,
  input  logic            pop_i,
  output fetch_entry_t    data_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

  // Head is forced to zero when empty so idle outputs read as zero.
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tinker_fetch_unit.sv
// Decoupled fetch stage: credit-limited request issue, in-order response tracking with
// redirect flush, and a prefetch queue feeding decode.
module tinker_fetch_unit
  import tinker_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = TINKER_RESET_PC,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  tinker_fetch_unit_if.master imem,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                halt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [XLEN-1:0]     out_pc4
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;

  logic [CntW-1:0] count;
  logic            fifo_full, fifo_empty;
  logic            credit_ok, req_fire, rsp_fire, push, pop;
  fetch_entry_t    push_entry, head;

  // Credits count queued plus in-flight words; a same-cycle pop is deliberately not credited.
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding_q}) < SumW'(DEPTH);

  assign imem.imem_req_valid = ~reset & ~halt & ~redirect_valid & credit_ok;
  assign imem.imem_req_addr  = fetch_pc_q;

  assign req_fire = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_fire = imem.imem_rsp_valid;
  assign push     = rsp_fire & ~redirect_valid & (drop_q == '0);
  assign pop      = out_valid & out_ready & ~redirect_valid;

  assign push_entry = '{instr: imem.imem_rsp_data, pc4: rsp_pc_q + XLEN'(4)};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_fire);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      // Everything still in flight is stale, minus the response being discarded right now.
      drop_d     = outstanding_q - CntW'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_fire) begin
        if (drop_q != '0) drop_d   = drop_q - CntW'(1);
        else              rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  tinker_fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_instr = head.instr;
  assign out_pc4   = head.pc4;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit with a variable-latency memory model and an
// expected-entry scoreboard keyed on fetch epochs.
module tb_tinker_fetch_unit;
  import tinker_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tinker_fetch_unit_if imem_if ();

  logic               redirect_valid, halt, out_valid, out_ready;
  logic [XLEN-1:0]    redirect_pc, out_pc4;
  logic [INSTR_W-1:0] out_instr;

  tinker_fetch_unit #(
    .RESET_PC (64'h2000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4)
  );

  typedef struct packed {
    logic [63:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t sb[$];

  int unsigned n_vec = 0, n_err = 0;
  int unsigned cyc = 0, lat = 1, epoch = 0;
  int unsigned n_acc = 0, n_pop = 0;
  logic [63:0] exp_fetch_pc, prev_addr, redir_target, last_addr;
  logic        prev_pend, want_first, rand_ready;
  logic        last_req_v, last_out_valid, last_rsp_valid;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_if.imem_req_valid, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_instr"}, out_instr, 32'h0);
    check({tag, "_out_pc4"}, out_pc4, 64'h0);
  endtask

  task automatic clear_model();
    mq.delete();
    sb.delete();
    epoch++;
    exp_fetch_pc = 64'h2000;
    prev_pend    = 1'b0;
    want_first   = 1'b0;
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_data  = '0;
  endtask

  // One clock cycle: called just after a negedge with this cycle's inputs set.
  task automatic tick();
    mreq_t        m;
    fetch_entry_t e;
    logic         req_v;
    logic [63:0]  addr;
    if (rand_ready) imem_if.imem_req_ready = 1'($urandom_range(0, 1));
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_if.imem_rsp_valid = 1'b1;
      imem_if.imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_if.imem_rsp_valid = 1'b0;
      imem_if.imem_rsp_data  = '0;
    end
    #2;
    req_v = imem_if.imem_req_valid;
    addr  = imem_if.imem_req_addr;
    if (prev_pend && !redirect_valid && !halt) begin
      check("req_hold_valid", req_v, 1'b1);
      check("req_hold_addr", addr, prev_addr);
    end
    if (redirect_valid) check("no_req_on_redirect", req_v, 1'b0);
    if (out_valid && out_ready && !redirect_valid) begin
      n_pop++;
      if (sb.size() == 0) begin
        check("pop_unexpected", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("out_pc4", out_pc4, e.pc4);
        check("out_instr", out_instr, e.instr);
        if (want_first) check("first_pc4_after_redirect", out_pc4, redir_target + 64'd4);
        want_first = 1'b0;
      end
    end
    if (imem_if.imem_rsp_valid) begin
      m = mq.pop_front();
      if (m.epoch == epoch && !redirect_valid)
        sb.push_back('{instr: mem_word(m.addr), pc4: m.addr + 64'd4});
    end
    if (redirect_valid) begin
      sb.delete();
      epoch++;
      exp_fetch_pc = redirect_pc;
      redir_target = redirect_pc;
      want_first   = 1'b1;
    end
    if (req_v && imem_if.imem_req_ready) begin
      check("req_addr", addr, exp_fetch_pc);
      exp_fetch_pc = exp_fetch_pc + 64'd4;
      mq.push_back('{addr: addr, due: cyc + lat, epoch: epoch});
      n_acc++;
    end
    prev_pend      = req_v && !imem_if.imem_req_ready;
    prev_addr      = addr;
    last_req_v     = req_v;
    last_addr      = addr;
    last_out_valid = out_valid;
    last_rsp_valid = imem_if.imem_rsp_valid;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    out_ready      = 1'b0;
    rand_ready     = 1'b0;
    imem_if.imem_req_ready = 1'b1;
    clear_model();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // First requests and reset-time fill with decode stalled.
    n_acc = 0;
    tick();
    check("t1_c0_out_valid", last_out_valid, 1'b0);
    check("t1_c0_req_valid", last_req_v, 1'b1);
    check("t1_c0_addr", last_addr, 64'h2000);
    tick();
    check("t1_c1_addr", last_addr, 64'h2004);
    check("t1_c1_out_valid", last_out_valid, 1'b0);
    repeat (8) tick();
    check("t3_accepts_when_full", n_acc, 4);
    check("t3_req_valid_full", last_req_v, 1'b0);
    check("t3_out_valid_full", last_out_valid, 1'b1);

    // Release decode: drain and resume at 0x2010, then steady one-per-cycle flow.
    out_ready = 1'b1;
    n_pop = 0;
    repeat (6) tick();
    check("t3_pops_after_release", n_pop, 6);
    n_pop = 0;
    repeat (10) tick();
    check("t2_throughput", n_pop, 10);

    // Redirect with several stale requests in flight on a 3-cycle memory.
    lat = 3;
    repeat (10) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    repeat (14) tick();
    check("t4_first_seen", want_first, 1'b0);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    tick();
    redirect_valid = 1'b0;
    check("t5_rsp_in_redirect", last_rsp_valid, 1'b1);
    check("t5_out_valid_in_redirect", last_out_valid, 1'b1);
    tick();
    check("t5_empty_after_redirect", last_out_valid, 1'b0);
    repeat (8) tick();
    check("t5_first_seen", want_first, 1'b0);

    // Memory back-pressure exercises request hold.
    rand_ready = 1'b1;
    repeat (24) tick();
    rand_ready = 1'b0;
    imem_if.imem_req_ready = 1'b1;

    // Halt with two queued and one in flight.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h5000;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    halt  = 1'b1;
    n_acc = 0;
    tick();
    check("t6_no_req_halt", last_req_v, 1'b0);
    repeat (4) tick();
    check("t6_no_accepts_halt", n_acc, 0);
    out_ready = 1'b1;
    n_pop = 0;
    repeat (5) tick();
    check("t6_drained_under_halt", n_pop, 3);
    halt = 1'b0;
    tick();
    check("t6_resume_valid", last_req_v, 1'b1);
    check("t6_resume_addr", last_addr, 64'h500C);

    // Asynchronous reset mid-stream.
    repeat (5) tick();
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (12) tick();

    // Final drain: nothing lost or duplicated.
    halt = 1'b1;
    repeat (10) tick();
    check("final_sb_empty", sb.size(), 0);
    check("final_mem_empty", mq.size(), 0);
    check("final_out_valid", last_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
